// File: rtl/mem_issue_pkg.sv
// ============================================================================
// Module   : mem_issue_pkg
// Purpose  : Shared configuration for the memory issue controller: default
//            queue depth, ROB index width, payload width and the queue entry
//            layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_issue_pkg;

    localparam int MEM_ISSUE_DEPTH     = 8;
    localparam int MEM_ISSUE_ROB_DEPTH = 64;
    localparam int ROB_IDX_W           = $clog2(MEM_ISSUE_ROB_DEPTH);
    localparam int MEM_ISSUE_PAYLOAD_W = 128;

    // Entry layout, most significant field first. The controller packs its
    // queue words in this same order: {store, rob_idx, payload}.
    typedef struct packed {
        logic                           store;
        logic [ROB_IDX_W-1:0]           rob_idx;
        logic [MEM_ISSUE_PAYLOAD_W-1:0] payload;
    } MemIssueEntrySt;

endpackage

`default_nettype wire

// File: rtl/mem_issue_fifo.sv
// ============================================================================
// Module   : mem_issue_fifo
// Purpose  : Generic circular buffer with wrap-bit pointers. Exposes the head
//            entry combinationally; push/pop must be pre-qualified by the
//            caller (no push when full, no pop when empty).
// Ports    : clk, rst_n (async assert, active low)
//            i_flush  - clear both pointers (priority over push/pop)
//            i_push   - write i_wdata at tail, advance tail
//            i_pop    - advance head
//            o_head   - head entry (don't-care when empty)
//            o_empty, o_full, o_count (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_issue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable when the index bits coincide.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage holds no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/mem_issue_ctrl.sv
// ============================================================================
// Module   : mem_issue_ctrl
// Purpose  : In-order issue controller between dispatch and the memory
//            execute pipeline. Loads issue as soon as they reach the head;
//            a store at the head waits until it is the oldest ROB entry,
//            which keeps speculative stores away from the DCache/AXI path.
// Ports    : clk, a_rst_n (async assert, sync deassert, active low)
//            flush_i                 - discard all queued ops
//            in_valid_i/in_ready_o   - dispatch handshake
//            in_store_i, in_rob_idx_i, in_payload_i - enqueued op
//            oldest_rob_idx_i        - current oldest ROB index
//            out_valid_o/out_ready_i - memory pipeline handshake
//            out_store_o, out_rob_idx_o, out_payload_o - head op
//            count_o                 - occupied entries (0..DEPTH)
//            store_stall_cnt_o       - saturating blocked-store cycle count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_issue_ctrl
    import mem_issue_pkg::*;
#(
    parameter int DEPTH     = MEM_ISSUE_DEPTH,
    parameter int ROB_DEPTH = MEM_ISSUE_ROB_DEPTH,
    parameter int PAYLOAD_W = MEM_ISSUE_PAYLOAD_W,
    localparam int RW       = $clog2(ROB_DEPTH)
) (
    input  logic                   clk,
    input  logic                   a_rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_store_i,
    input  logic [RW-1:0]          in_rob_idx_i,
    input  logic [PAYLOAD_W-1:0]   in_payload_i,
    input  logic [RW-1:0]          oldest_rob_idx_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_store_o,
    output logic [RW-1:0]          out_rob_idx_o,
    output logic [PAYLOAD_W-1:0]   out_payload_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [31:0]            store_stall_cnt_o
);

    localparam int ENTRY_W = 1 + RW + PAYLOAD_W;

    // ------------------------------------------------------------------
    // Reset synchronizer: assertion reaches the state immediately,
    // release is retimed through two flops.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [ENTRY_W-1:0] w_head;
    logic               w_head_store;
    logic [RW-1:0]      w_head_rob;
    logic               w_head_is_oldest;

    mem_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_wdata ({in_store_i, in_rob_idx_i, in_payload_i}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count_o)
    );

    assign w_head_store     = w_head[ENTRY_W-1];
    assign w_head_rob       = w_head[ENTRY_W-2 -: RW];
    assign w_head_is_oldest = (w_head_rob == oldest_rob_idx_i);

    // Ready is withheld while the synchronized reset is still held so that
    // no handshake is acknowledged into flops that cannot yet capture it.
    // A dequeue in the same cycle does not free a slot for a full queue.
    assign in_ready_o = ~w_full & ~flush_i & w_rst_n;
    assign w_push     = in_valid_i & in_ready_o;

    // Ordering gate: a store issues only when non-speculative. The head is
    // never skipped, so a blocked store also holds back younger loads.
    assign out_valid_o   = ~w_empty & ~flush_i & (~w_head_store | w_head_is_oldest);
    assign w_pop         = out_valid_o & out_ready_i;
    assign out_store_o   = w_head_store;
    assign out_rob_idx_o = w_head_rob;
    assign out_payload_o = w_head[PAYLOAD_W-1:0];

    // ------------------------------------------------------------------
    // Store stall counter: survives flush, saturates at all-ones.
    // ------------------------------------------------------------------
    logic        w_store_stall;
    logic [31:0] r_stall_cnt;

    assign w_store_stall = ~w_empty & w_head_store & ~w_head_is_oldest & ~flush_i;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_store_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign store_stall_cnt_o = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_issue_ctrl.sv
// ============================================================================
// Module   : tb_mem_issue_ctrl
// Purpose  : Directed self-checking bench for mem_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_issue_ctrl;

    localparam int DEPTH     = 8;
    localparam int ROB_DEPTH = 64;
    localparam int PAYLOAD_W = 128;
    localparam int RW        = 6;

    logic                 clk;
    logic                 a_rst_n;
    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 in_store_i;
    logic [RW-1:0]        in_rob_idx_i;
    logic [PAYLOAD_W-1:0] in_payload_i;
    logic [RW-1:0]        oldest_rob_idx_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 out_store_o;
    logic [RW-1:0]        out_rob_idx_o;
    logic [PAYLOAD_W-1:0] out_payload_o;
    logic [3:0]           count_o;
    logic [31:0]          store_stall_cnt_o;

    int r_checks;
    int r_errors;

    mem_issue_ctrl #(
        .DEPTH     (DEPTH),
        .ROB_DEPTH (ROB_DEPTH),
        .PAYLOAD_W (PAYLOAD_W)
    ) dut (
        .clk               (clk),
        .a_rst_n           (a_rst_n),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_store_i        (in_store_i),
        .in_rob_idx_i      (in_rob_idx_i),
        .in_payload_i      (in_payload_i),
        .oldest_rob_idx_i  (oldest_rob_idx_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_store_o       (out_store_o),
        .out_rob_idx_o     (out_rob_idx_o),
        .out_payload_o     (out_payload_o),
        .count_o           (count_o),
        .store_stall_cnt_o (store_stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after
    // the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pay(input int r);
        logic [31:0] v;
        v = 32'(r);
        return {v ^ 32'hC0DE_5A5A, 64'h0, v};
    endfunction

    task automatic drive_op(input logic st, input int r);
        in_valid_i   = 1'b1;
        in_store_i   = st;
        in_rob_idx_i = RW'(r);
        in_payload_i = pay(r);
    endtask

    task automatic release_reset();
        @(negedge clk);
        a_rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        r_checks         = 0;
        r_errors         = 0;
        a_rst_n          = 1'b0;
        flush_i          = 1'b0;
        in_valid_i       = 1'b0;
        in_store_i       = 1'b0;
        in_rob_idx_i     = '0;
        in_payload_i     = '0;
        oldest_rob_idx_i = '0;
        out_ready_i      = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check("rst_count", 128'(count_o), 128'd0);
        check("rst_valid", 128'(out_valid_o), 128'd0);
        check("rst_stall", 128'(store_stall_cnt_o), 128'd0);
        release_reset();
        check("rst_in_ready", 128'(in_ready_o), 128'd1);

        // ---------------- single load, 1-cycle latency ----------------
        drive_op(1'b0, 5);
        out_ready_i = 1'b1;
        #1;
        check("ld_no_bypass", 128'(out_valid_o), 128'd0);
        tick();
        in_valid_i = 1'b0;
        #1;
        check("ld_valid", 128'(out_valid_o), 128'd1);
        check("ld_rob", 128'(out_rob_idx_o), 128'd5);
        check("ld_payload", out_payload_o, pay(5));
        check("ld_count1", 128'(count_o), 128'd1);
        tick();
        check("ld_count0", 128'(count_o), 128'd0);

        // ---------------- blocked store ----------------
        oldest_rob_idx_i = RW'(3);
        drive_op(1'b1, 7);
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("st_blocked", 128'(out_valid_o), 128'd0);
            tick();
        end
        check("st_stall4", 128'(store_stall_cnt_o), 128'd4);
        oldest_rob_idx_i = RW'(7);
        #1;
        check("st_valid", 128'(out_valid_o), 128'd1);
        check("st_store", 128'(out_store_o), 128'd1);
        tick();
        check("st_count0", 128'(count_o), 128'd0);
        check("st_stall_hold", 128'(store_stall_cnt_o), 128'd4);

        // ---------------- fill to full, drain across wrap ----------------
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_op(1'b0, 10 + i);
            tick();
        end
        check("full_count", 128'(count_o), 128'd8);
        check("full_in_ready", 128'(in_ready_o), 128'd0);
        drive_op(1'b0, 18);
        out_ready_i = 1'b1;
        #1;
        check("full_pop_in_ready", 128'(in_ready_o), 128'd0);
        check("full_head_rob", 128'(out_rob_idx_o), 128'd10);
        tick();
        check("after_pop_in_ready", 128'(in_ready_o), 128'd1);
        check("after_pop_count", 128'(count_o), 128'd7);
        for (int k = 1; k <= 3; k++) begin
            check("wrap_rob_a", 128'(out_rob_idx_o), 128'(10 + k));
            tick();
            drive_op(1'b0, 18 + k);
        end
        in_valid_i = 1'b0;
        #1;
        check("wrap_count7", 128'(count_o), 128'd7);
        for (int k = 0; k < 7; k++) begin
            check("wrap_rob_b", 128'(out_rob_idx_o), 128'(14 + k));
            check("wrap_payload", out_payload_o, pay(14 + k));
            tick();
        end
        check("wrap_count0", 128'(count_o), 128'd0);

        // ---------------- store blocks younger load ----------------
        oldest_rob_idx_i = RW'(0);
        drive_op(1'b1, 2);
        tick();
        drive_op(1'b0, 3);
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("order_blocked", 128'(out_valid_o), 128'd0);
            tick();
        end
        check("order_count", 128'(count_o), 128'd2);
        check("order_stall", 128'(store_stall_cnt_o), 128'd7);
        oldest_rob_idx_i = RW'(2);
        #1;
        check("order_st_valid", 128'(out_valid_o), 128'd1);
        check("order_st_first", 128'(out_store_o), 128'd1);
        check("order_st_rob", 128'(out_rob_idx_o), 128'd2);
        tick();
        check("order_ld_valid", 128'(out_valid_o), 128'd1);
        check("order_ld_store", 128'(out_store_o), 128'd0);
        check("order_ld_rob", 128'(out_rob_idx_o), 128'd3);
        tick();
        check("order_count0", 128'(count_o), 128'd0);

        // ---------------- flush ----------------
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_op(1'b0, 20 + i);
            tick();
        end
        check("fl_count5", 128'(count_o), 128'd5);
        drive_op(1'b0, 40);
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        check("fl_in_ready", 128'(in_ready_o), 128'd0);
        check("fl_out_valid", 128'(out_valid_o), 128'd0);
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("fl_count0", 128'(count_o), 128'd0);
        check("fl_in_ready_after", 128'(in_ready_o), 128'd1);
        check("fl_valid_after", 128'(out_valid_o), 128'd0);
        check("fl_stall_kept", 128'(store_stall_cnt_o), 128'd7);

        // ---------------- asynchronous reset mid-operation ----------------
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 30 + i);
            tick();
        end
        in_valid_i = 1'b0;
        check("ar_count3", 128'(count_o), 128'd3);
        check("ar_valid_pre", 128'(out_valid_o), 128'd1);
        #2;
        a_rst_n = 1'b0;
        #1;
        check("ar_valid_now", 128'(out_valid_o), 128'd0);
        check("ar_count_now", 128'(count_o), 128'd0);
        check("ar_stall_now", 128'(store_stall_cnt_o), 128'd0);
        out_ready_i = 1'b1;
        tick();
        release_reset();
        check("ar_count_after", 128'(count_o), 128'd0);
        check("ar_valid_after", 128'(out_valid_o), 128'd0);
        check("ar_in_ready_after", 128'(in_ready_o), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire
